// File: rtl/piso_pkg.sv
// Shared types for the parallel-in serial-out transmitter.
package piso_pkg;

    // Transmitter control states.
    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } piso_state_t;

endpackage

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter. Words arrive on a valid/ready handshake and
// leave one bit per clock on a registered serial line with a frame strobe.
module piso_tx
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter bit          IDLE_LEVEL = 1'b0,
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             ser_out,
    output logic             ser_frame,
    output logic             tx_done,
    output logic             busy
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt   = CntW'(WIDTH - 1);
    localparam logic [CntW-1:0] PenultCnt = CntW'(WIDTH - 2);

    piso_state_t      state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
    logic             ser_out_q, ser_out_d;
    logic             frame_q, frame_d;
    logic             done_q, done_d;
    logic             last_bit;
    logic             transfer;
    logic             gap_start;
    logic             gap_done;

    // bit_cnt tracks the bit currently on the line, so last_bit marks its final cycle.
    assign last_bit = (bit_cnt_q == LastCnt);
    assign transfer = tx_valid && tx_ready;

    // Ready depends only on state; a reload on the last bit gives gapless streaming.
    always_comb begin
        tx_ready = 1'b0;
        unique case (state_q)
            IDLE:    tx_ready = 1'b1;
            SHIFT:   tx_ready = (GAP_CYCLES == 0) && last_bit;
            default: tx_ready = 1'b0;
        endcase
    end

    // Next-state, shift path and registered-output next values.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        ser_out_d = IDLE_LEVEL;
        frame_d   = 1'b0;
        done_d    = 1'b0;
        gap_start = 1'b0;
        if (transfer) begin
            // First bit goes straight to the line; the rest waits in shift_q.
            state_d   = SHIFT;
            bit_cnt_d = '0;
            frame_d   = 1'b1;
            if (MSB_FIRST) begin
                ser_out_d = tx_data[WIDTH-1];
                shift_d   = {tx_data[WIDTH-2:0], 1'b0};
            end else begin
                ser_out_d = tx_data[0];
                shift_d   = {1'b0, tx_data[WIDTH-1:1]};
            end
        end else begin
            unique case (state_q)
                IDLE: ;
                SHIFT: begin
                    if (!last_bit) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        frame_d   = 1'b1;
                        done_d    = (bit_cnt_q == PenultCnt);
                        if (MSB_FIRST) begin
                            ser_out_d = shift_q[WIDTH-1];
                            shift_d   = {shift_q[WIDTH-2:0], 1'b0};
                        end else begin
                            ser_out_d = shift_q[0];
                            shift_d   = {1'b0, shift_q[WIDTH-1:1]};
                        end
                    end else if (GAP_CYCLES > 0) begin
                        state_d   = GAP;
                        gap_start = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                GAP: begin
                    if (gap_done) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers; reset drops any word in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            ser_out_q <= IDLE_LEVEL;
            frame_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            ser_out_q <= ser_out_d;
            frame_q   <= frame_d;
            done_q    <= done_d;
        end
    end

    if (GAP_CYCLES > 0) begin : g_gap
        localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);
        logic [GapW-1:0] gap_cnt_q;

        // Count cycles spent in GAP, restarting from zero on each entry.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                gap_cnt_q <= '0;
            end else if (gap_start) begin
                gap_cnt_q <= '0;
            end else if (state_q == GAP) begin
                gap_cnt_q <= gap_cnt_q + 1'b1;
            end
        end

        assign gap_done = (gap_cnt_q == GapW'(GAP_CYCLES - 1));
    end else begin : g_no_gap
        logic unused_gap_start;
        assign unused_gap_start = gap_start;
        assign gap_done         = 1'b1;
    end

    assign ser_out   = ser_out_q;
    assign ser_frame = frame_q;
    assign tx_done   = done_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: two instances (MSB-first gapless, LSB-first with idle gap and
// high idle level) checked cycle by cycle against a schedule-based model plus a
// word-level scoreboard that reassembles the serial stream.
module tb_piso_tx;

    localparam int unsigned W = 8;
    localparam int N  = 8192;
    localparam int NW = 1024;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic [W-1:0] tx_data   [2];
    logic         tx_valid  [2];
    logic         tx_ready  [2];
    logic         ser_out   [2];
    logic         ser_frame [2];
    logic         tx_done   [2];
    logic         busy      [2];

    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0), .GAP_CYCLES(0)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .ser_out(ser_out[0]), .ser_frame(ser_frame[0]),
        .tx_done(tx_done[0]), .busy(busy[0])
    );

    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1), .GAP_CYCLES(3)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .ser_out(ser_out[1]), .ser_frame(ser_frame[1]),
        .tx_done(tx_done[1]), .busy(busy[1])
    );

    always #5 clk = ~clk;

    // Per-instance configuration as seen by the model.
    bit msb_of  [2] = '{1'b1, 1'b0};
    bit idle_of [2] = '{1'b0, 1'b1};
    int gap_of  [2] = '{0, 3};

    // Expected line contents indexed by cycle number.
    logic exp_frame [2][N];
    logic exp_bit   [2][N];
    logic exp_done  [2][N];
    int   next_ready [2];
    int   busy_until [2];

    logic [W-1:0] pend_buf [2][NW];
    logic [W-1:0] sent_buf [2][NW];
    int           pend_rd [2], pend_wr [2], sent_rd [2], sent_wr [2];
    logic [W-1:0] cap [2];

    int cyc;
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic clear_model(input int from);
        for (int i = 0; i < 2; i++) begin
            for (int c = from; c < N; c++) begin
                exp_frame[i][c] = 1'b0;
                exp_bit[i][c]   = 1'b0;
                exp_done[i][c]  = 1'b0;
            end
            next_ready[i] = 0;
            busy_until[i] = -1;
            pend_rd[i]    = pend_wr[i];
            sent_rd[i]    = sent_wr[i];
        end
    endtask

    task automatic push(input int i, input logic [W-1:0] w);
        if (pend_wr[i] < NW) begin
            pend_buf[i][pend_wr[i]] = w;
            pend_wr[i]++;
        end
    endtask

    task automatic check_idle(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_ser_out%0d", tag, i), 32'(ser_out[i]), 32'(idle_of[i]));
            check($sformatf("%s_frame%0d", tag, i), 32'(ser_frame[i]), 0);
            check($sformatf("%s_done%0d", tag, i), 32'(tx_done[i]), 0);
            check($sformatf("%s_ready%0d", tag, i), 32'(tx_ready[i]), 1);
            check($sformatf("%s_busy%0d", tag, i), 32'(busy[i]), 0);
        end
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic cycle(input bit rnd);
        for (int i = 0; i < 2; i++) begin
            if (pend_rd[i] != pend_wr[i] && !(rnd && $urandom_range(0, 4) == 0)) begin
                tx_valid[i] = 1'b1;
                tx_data[i]  = pend_buf[i][pend_rd[i]];
            end else begin
                tx_valid[i] = 1'b0;
                tx_data[i]  = W'($urandom);
            end
        end
        for (int i = 0; i < 2; i++) begin
            logic eo;
            eo = exp_frame[i][cyc] ? exp_bit[i][cyc] : idle_of[i];
            check($sformatf("ser_out%0d", i), 32'(ser_out[i]), 32'(eo));
            check($sformatf("frame%0d", i), 32'(ser_frame[i]), 32'(exp_frame[i][cyc]));
            check($sformatf("done%0d", i), 32'(tx_done[i]), 32'(exp_done[i][cyc]));
            check($sformatf("ready%0d", i), 32'(tx_ready[i]), 32'(cyc >= next_ready[i]));
            check($sformatf("busy%0d", i), 32'(busy[i]), 32'(cyc <= busy_until[i]));
            if (ser_frame[i] === 1'b1) begin
                cap[i] = msb_of[i] ? {cap[i][W-2:0], ser_out[i]} : {ser_out[i], cap[i][W-1:1]};
            end
            if (tx_done[i] === 1'b1) begin
                if (sent_rd[i] == sent_wr[i]) begin
                    check($sformatf("spurious_done%0d", i), 32'(tx_done[i]), 0);
                end else begin
                    check($sformatf("word%0d", i), 32'(cap[i]), 32'(sent_buf[i][sent_rd[i]]));
                    sent_rd[i]++;
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (tx_valid[i] && cyc >= next_ready[i]) begin
                logic [W-1:0] d;
                d = tx_data[i];
                for (int k = 0; k < int'(W); k++) begin
                    exp_frame[i][cyc+1+k] = 1'b1;
                    exp_bit[i][cyc+1+k]   = msb_of[i] ? d[W-1-k] : d[k];
                end
                exp_done[i][cyc+W] = 1'b1;
                next_ready[i] = (gap_of[i] == 0) ? cyc + W : cyc + W + gap_of[i] + 1;
                busy_until[i] = cyc + W + gap_of[i];
                sent_buf[i][sent_wr[i]] = d;
                sent_wr[i]++;
                pend_rd[i]++;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    // Asynchronous reset asserted between edges; idle outputs must appear at once.
    task automatic mid_reset();
        for (int i = 0; i < 2; i++) tx_valid[i] = 1'b0;
        #2 reset_n = 1'b0;
        #1 check_idle("mid_reset");
        clear_model(cyc);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        cycle(1'b0);
        cycle(1'b0);
        reset_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            tx_valid[i] = 1'b0;
            tx_data[i]  = '0;
            pend_rd[i] = 0; pend_wr[i] = 0; sent_rd[i] = 0; sent_wr[i] = 0;
            cap[i] = '0;
        end
        cyc = 0;
        clear_model(0);

        // Reset applied before the first clock edge.
        #3 reset_n = 1'b0;
        #1 check_idle("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Single words: 0xA5 MSB-first; 0xA5 then 0x01 LSB-first with idle gap.
        push(0, 8'hA5);
        push(1, 8'hA5);
        push(1, 8'h01);
        for (int n = 0; n < 30; n++) cycle(1'b0);

        // Gapless back-to-back with valid held.
        push(0, 8'hF0);
        push(0, 8'h0F);
        for (int n = 0; n < 25; n++) cycle(1'b0);

        // Reset in the middle of 0xFF, then a clean 0x81.
        push(0, 8'hFF);
        for (int n = 0; n < 5; n++) cycle(1'b0);
        mid_reset();
        push(0, 8'h81);
        push(1, 8'h81);
        for (int n = 0; n < 25; n++) cycle(1'b0);

        // Random words with random valid bubbles.
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (pend_wr[i] - pend_rd[i] < 2 && $urandom_range(0, 2) != 0) push(i, W'($urandom));
            end
            cycle(1'b1);
        end

        // Drain: every accepted word must have been delivered.
        for (int n = 0; n < 40; n++) cycle(1'b0);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("undelivered%0d", i), 32'(sent_wr[i] - sent_rd[i]), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
